// File: rtl/random_engine_dpath.sv
// random_engine_dpath
//   Galois LFSR datapath that sits behind the random engine controller.
//   Each accepted advance produces one new sample. The sample is held in a
//   one-entry val/rdy output register. Under backpressure the LFSR stalls,
//   so no value is ever dropped or repeated.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   lfsr_en     in   advance request from the controller
//   seed_load   in   one-cycle pulse, load seed_data into the LFSR
//   seed_data   in   [WIDTH] seed value (zero is replaced by SEED)
//   out_val     out  out_data holds an unconsumed sample
//   out_rdy     in   consumer takes the sample this cycle
//   out_data    out  [WIDTH] current sample
//   stall       out  advance requested but blocked by backpressure
//   zero_seed   out  sticky, a zero seed was substituted
//   sample_cnt  out  [CNT_W] saturating count of accepted transfers
module random_engine_dpath #(
  parameter int                 WIDTH = 16,
  parameter logic [WIDTH-1:0]   TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0]   SEED  = 16'hACE1,
  parameter int                 CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lfsr_en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_data,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             stall,
  output logic             zero_seed,
  output logic [CNT_W-1:0] sample_cnt
);

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             val_q,  val_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  logic             xfer, adv, seed_zero;
  logic [WIDTH-1:0] lfsr_nxt;

  assign xfer      = val_q & out_rdy;
  // The output slot is free if it is empty or is being drained this cycle.
  // That free slot is what allows one sample per cycle at full rate.
  assign adv       = lfsr_en & ~seed_load & (~val_q | out_rdy);
  assign stall     = lfsr_en & ~seed_load & val_q & ~out_rdy;
  assign seed_zero = (seed_data == '0);
  assign lfsr_nxt  = lfsr_step(lfsr_q);

  always_comb begin
    lfsr_d = lfsr_q;
    data_d = data_q;
    val_d  = val_q;
    zero_d = zero_q;
    cnt_d  = cnt_q;
    if (seed_load) begin
      // A reseed wins over everything. Any pending sample is discarded and
      // is not counted. out_data keeps its last value.
      lfsr_d = seed_zero ? SEED : seed_data;
      zero_d = zero_q | seed_zero;
      val_d  = 1'b0;
      cnt_d  = '0;
    end else begin
      if (adv) begin
        lfsr_d = lfsr_nxt;
        data_d = lfsr_nxt;
        val_d  = 1'b1;
      end else if (xfer) begin
        val_d  = 1'b0;
      end
      if (xfer && (cnt_q != '1))
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED;
      data_q <= '0;
      val_q  <= 1'b0;
      zero_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      data_q <= data_d;
      val_q  <= val_d;
      zero_q <= zero_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_val    = val_q;
  assign out_data   = data_q;
  assign zero_seed  = zero_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_random_engine_dpath.sv
module tb_random_engine_dpath;
  localparam logic [15:0] TAPS = 16'hB400;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lfsr_en = 1'b0, seed_load = 1'b0, out_rdy = 1'b0;
  logic [15:0] seed_data = '0;
  logic        out_val, stall, zero_seed;
  logic [15:0] out_data;
  logic [31:0] sample_cnt;
  logic        out_val4, stall4, zero_seed4;
  logic [15:0] out_data4;
  logic [3:0]  sample_cnt4;

  int n_chk = 0, n_fail = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  random_engine_dpath dut (
    .clk(clk), .rst(rst), .lfsr_en(lfsr_en), .seed_load(seed_load),
    .seed_data(seed_data), .out_val(out_val), .out_rdy(out_rdy),
    .out_data(out_data), .stall(stall), .zero_seed(zero_seed),
    .sample_cnt(sample_cnt));

  random_engine_dpath #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .lfsr_en(lfsr_en), .seed_load(seed_load),
    .seed_data(seed_data), .out_val(out_val4), .out_rdy(out_rdy),
    .out_data(out_data4), .stall(stall4), .zero_seed(zero_seed4),
    .sample_cnt(sample_cnt4));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  // Reference model + scoreboard of produced samples
  logic [15:0] m_state;
  logic        m_val, m_zero;
  logic [31:0] m_cnt;
  logic [3:0]  m_cnt4;
  logic [15:0] sb[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state <= SEED; m_val <= 1'b0; m_zero <= 1'b0;
      m_cnt <= '0; m_cnt4 <= '0;
      sb.delete();
    end else if (seed_load) begin
      m_state <= (seed_data == 16'h0) ? SEED : seed_data;
      m_zero  <= m_zero | (seed_data == 16'h0);
      m_val   <= 1'b0; m_cnt <= '0; m_cnt4 <= '0;
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      if (m_val && out_rdy) begin
        if (sb.size() > 0) void'(sb.pop_front());
        if (m_cnt  != 32'hFFFF_FFFF) m_cnt  <= m_cnt + 1;
        if (m_cnt4 != 4'hF)          m_cnt4 <= m_cnt4 + 4'd1;
      end
      if (lfsr_en && (!m_val || out_rdy)) begin
        m_state <= step(m_state);
        sb.push_back(step(m_state));
        m_val   <= 1'b1;
      end else if (m_val && out_rdy) begin
        m_val <= 1'b0;
      end
    end
  end

  // Per-cycle monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (mon_en && rst) begin
      chk("val", out_val, m_val);
      chk("cnt", sample_cnt, m_cnt);
      chk("cnt4", sample_cnt4, m_cnt4);
      chk("zero", zero_seed, m_zero);
      chk("stall", stall, lfsr_en & ~seed_load & m_val & ~out_rdy);
      if (m_val && sb.size() > 0) chk("data", out_data, sb[0]);
    end
  end

  initial begin
    // reset values, no clock edge yet
    #2;
    chk("rst_val", out_val, 0);
    chk("rst_data", out_data, 0);
    chk("rst_zero", zero_seed, 0);
    chk("rst_cnt", sample_cnt, 0);
    chk("rst_stall", stall, 0);

    // basic sequence at full rate
    @(negedge clk); #1;
    rst = 1'b1; mon_en = 1'b1; lfsr_en = 1'b1; out_rdy = 1'b1;
    @(negedge clk); chk("seq0", out_data, 16'hE270); chk("seq_val", out_val, 1);
    @(negedge clk); chk("seq1", out_data, 16'h7138);
    @(negedge clk); chk("seq2", out_data, 16'h389C);
    #1 lfsr_en = 1'b0;
    @(negedge clk); chk("seq_cnt", sample_cnt, 3); chk("seq_idle", out_val, 0);

    // backpressure, restarting from reset
    #1 rst = 1'b0; out_rdy = 1'b0;
    #2 rst = 1'b1; lfsr_en = 1'b1;
    @(negedge clk); chk("bp_first", out_data, 16'hE270);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold", out_data, 16'hE270);
      chk("bp_stall", stall, 1);
      chk("bp_cnt", sample_cnt, 0);
    end
    #1 out_rdy = 1'b1;
    @(negedge clk); chk("bp_next", out_data, 16'h7138); chk("bp_cnt1", sample_cnt, 1);

    // reseed with a pending sample
    #1 out_rdy = 1'b0; lfsr_en = 1'b0; seed_load = 1'b1; seed_data = 16'h0001;
    @(negedge clk); chk("rs_val", out_val, 0); chk("rs_cnt", sample_cnt, 0);
    #1 seed_load = 1'b0; lfsr_en = 1'b1; out_rdy = 1'b1;
    @(negedge clk); chk("rs_data", out_data, 16'hB400);

    // zero seed substitution
    #1 lfsr_en = 1'b0; seed_load = 1'b1; seed_data = 16'h0000;
    @(negedge clk); chk("zs_flag", zero_seed, 1); chk("zs_val", out_val, 0);
    #1 seed_load = 1'b0; lfsr_en = 1'b1;
    @(negedge clk); chk("zs_data", out_data, 16'hE270); chk("zs_sticky", zero_seed, 1);

    // seed_load together with lfsr_en and a transfer: the seed wins
    #1 seed_load = 1'b1; seed_data = 16'h1234;
    @(negedge clk);
    chk("sim_val", out_val, 0); chk("sim_cnt", sample_cnt, 0);
    chk("sim_hold", out_data, 16'hE270);
    #1 seed_load = 1'b0;
    @(negedge clk); chk("sim_next", out_data, 16'h091A);

    // asynchronous reset between edges
    #3 rst = 1'b0;
    #1;
    chk("ar_val", out_val, 0); chk("ar_data", out_data, 0);
    chk("ar_cnt", sample_cnt, 0); chk("ar_zero", zero_seed, 0);
    chk("ar_stall", stall, 0);
    rst = 1'b1;
    @(negedge clk); chk("ar_seq0", out_data, 16'hE270);
    @(negedge clk); chk("ar_seq1", out_data, 16'h7138);

    // saturation of the narrow counter
    repeat (22) @(negedge clk);
    chk("sat4", sample_cnt4, 4'hF);
    chk("cnt32", sample_cnt, 23);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
